// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Package : dmem_pkg
// Brief   : Shared types, size codes and helpers for the data-memory controller.
// Rev     : 1.0  initial release
// ============================================================================
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam int TIMEOUT_CYCLES_DEF = 255;

    function automatic logic [7:0] byte_mask(input logic [1:0] size);
        logic [7:0] m;
        case (size)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // True when the low address bits are not a multiple of the access size.
    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
        logic r;
        case (size)
            SZ_B:    r = 1'b0;
            SZ_H:    r = off[0];
            SZ_W:    r = |off[1:0];
            default: r = |off;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module  : dmem_lane_align
// Brief   : Store byte-lane shift / byte enables and load shift / extension.
// Rev     : 1.0  initial release
// ============================================================================
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [1:0]      i_st_size,
    input  logic [2:0]      i_st_off,
    input  logic [XLEN-1:0] i_st_data,
    output logic [7:0]      o_be,
    output logic [XLEN-1:0] o_wdata,
    input  logic [2:0]      i_ld_funct3,
    input  logic [2:0]      i_ld_off,
    input  logic [XLEN-1:0] i_rdata,
    output logic [XLEN-1:0] o_ld_data
);

    logic [XLEN-1:0] w_ld_shift;
    logic            w_sx;

    assign o_be       = byte_mask(i_st_size) << i_st_off;
    assign o_wdata    = i_st_data << {i_st_off, 3'b000};
    assign w_ld_shift = i_rdata >> {i_ld_off, 3'b000};

    // Doubleword loads have no sign bit to replicate, so funct3[2] is ignored there.
    always_comb begin
        w_sx      = 1'b0;
        o_ld_data = w_ld_shift;
        case (i_ld_funct3[1:0])
            SZ_B: begin
                w_sx      = ~i_ld_funct3[2] & w_ld_shift[7];
                o_ld_data = {{(XLEN-8){w_sx}}, w_ld_shift[7:0]};
            end
            SZ_H: begin
                w_sx      = ~i_ld_funct3[2] & w_ld_shift[15];
                o_ld_data = {{(XLEN-16){w_sx}}, w_ld_shift[15:0]};
            end
            SZ_W: begin
                w_sx      = ~i_ld_funct3[2] & w_ld_shift[31];
                o_ld_data = {{(XLEN-32){w_sx}}, w_ld_shift[31:0]};
            end
            default: o_ld_data = w_ld_shift;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dmem_access_ctrl
// Brief   : MEM-stage load/store sequencer for a req/ack data-memory port.
//           Define DMEM_TIMEOUT_EN to add a watchdog on the request state.
// Rev     : 1.0  initial release
// ============================================================================
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int XLEN = 64
`ifdef DMEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            MEM_V,
    input  logic            MEM_LOAD,
    input  logic            MEM_STORE,
    input  logic [2:0]      MEM_FUNCT3,
    input  logic [XLEN-1:0] MEM_ADDR,
    input  logic [XLEN-1:0] MEM_STORE_DATA,
    input  logic            WB_STALL,
    output logic            DMEM_REQ,
    output logic            DMEM_WE,
    output logic [XLEN-1:0] DMEM_ADDR,
    output logic [XLEN-1:0] DMEM_WDATA,
    output logic [7:0]      DMEM_BE,
    input  logic            DMEM_ACK,
    input  logic            DMEM_ERR,
    input  logic [XLEN-1:0] DMEM_RDATA,
    output logic            MEM_STALL,
    output logic [XLEN-1:0] MEM_RESULT,
    output logic            MEM_LAM,
    output logic            MEM_LAF,
    output logic            MEM_SAM,
    output logic            MEM_SAF
);

    state_t          r_state;
    state_t          w_next_state;

    logic            w_access;
    logic            w_is_load;
    logic            w_is_store;
    logic            w_misaligned;
    logic            w_start;
    logic            w_ack;
    logic            w_timeout;

    logic            r_is_load;
    logic            r_we;
    logic            r_err;
    logic [2:0]      r_funct3;
    logic [2:0]      r_off;
    logic [7:0]      r_be;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_result;

    logic [7:0]      w_be;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_ld_data;

    // A load+store encoding is resolved as a load.
    assign w_access     = MEM_V & (MEM_LOAD | MEM_STORE);
    assign w_is_load    = MEM_LOAD;
    assign w_is_store   = MEM_STORE & ~MEM_LOAD;
    assign w_misaligned = misaligned(MEM_FUNCT3[1:0], MEM_ADDR[2:0]);
    assign w_start      = (r_state == ST_IDLE) & w_access & ~w_misaligned;
    assign w_ack        = (r_state == ST_REQ) & DMEM_ACK;

    dmem_lane_align #(
        .XLEN (XLEN)
    ) u_lane_align (
        .i_st_size   (MEM_FUNCT3[1:0]),
        .i_st_off    (MEM_ADDR[2:0]),
        .i_st_data   (MEM_STORE_DATA),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .i_ld_funct3 (r_funct3),
        .i_ld_off    (r_off),
        .i_rdata     (DMEM_RDATA),
        .o_ld_data   (w_ld_data)
    );

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK) begin
        if (RESET || w_start) begin
            r_cnt <= '0;
        end else if (r_state == ST_REQ) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_timeout = (r_state == ST_REQ) & ~DMEM_ACK & (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_next_state = ST_REQ;
            ST_REQ:  if (w_ack || w_timeout) w_next_state = ST_DONE;
            ST_DONE: if (!WB_STALL) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_is_load <= 1'b0;
            r_we      <= 1'b0;
            r_err     <= 1'b0;
            r_funct3  <= '0;
            r_off     <= '0;
            r_be      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_result  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_start) begin
                r_is_load <= w_is_load;
                r_we      <= w_is_store;
                r_funct3  <= MEM_FUNCT3;
                r_off     <= MEM_ADDR[2:0];
                r_be      <= w_be;
                r_addr    <= {MEM_ADDR[XLEN-1:3], 3'b000};
                r_wdata   <= w_wdata;
            end
            // Faulted accesses return zero rather than whatever the bus drove.
            if (w_ack) begin
                r_err    <= DMEM_ERR;
                r_result <= (r_is_load && !DMEM_ERR) ? w_ld_data : '0;
            end else if (w_timeout) begin
                r_err    <= 1'b1;
                r_result <= '0;
            end
        end
    end

    assign DMEM_REQ   = (r_state == ST_REQ);
    assign DMEM_WE    = r_we;
    assign DMEM_ADDR  = r_addr;
    assign DMEM_WDATA = r_wdata;
    assign DMEM_BE    = r_be;

    assign MEM_STALL  = w_access & (r_state != ST_DONE) & ~w_misaligned;
    assign MEM_RESULT = r_result;
    assign MEM_LAM    = (r_state == ST_IDLE) & w_access & w_misaligned & w_is_load;
    assign MEM_SAM    = (r_state == ST_IDLE) & w_access & w_misaligned & w_is_store;
    assign MEM_LAF    = (r_state == ST_DONE) & r_is_load & r_err;
    assign MEM_SAF    = (r_state == ST_DONE) & ~r_is_load & r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_access_ctrl
// Brief   : Directed self-checking bench for dmem_access_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
module tb_dmem_access_ctrl;

    localparam int TB_TO = 4;

    logic        clk;
    logic        rst;
    logic        mem_v, mem_load, mem_store;
    logic [2:0]  mem_funct3;
    logic [63:0] mem_addr, mem_sdata;
    logic        wb_stall;
    logic        dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata;
    logic [7:0]  dmem_be;
    logic        dmem_ack, dmem_err;
    logic [63:0] dmem_rdata;
    logic        mem_stall;
    logic [63:0] mem_result;
    logic        mem_lam, mem_laf, mem_sam, mem_saf;

    dmem_access_ctrl #(
        .XLEN           (64)
`ifdef DMEM_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TB_TO)
`endif
    ) dut (
        .CLK            (clk),
        .RESET          (rst),
        .MEM_V          (mem_v),
        .MEM_LOAD       (mem_load),
        .MEM_STORE      (mem_store),
        .MEM_FUNCT3     (mem_funct3),
        .MEM_ADDR       (mem_addr),
        .MEM_STORE_DATA (mem_sdata),
        .WB_STALL       (wb_stall),
        .DMEM_REQ       (dmem_req),
        .DMEM_WE        (dmem_we),
        .DMEM_ADDR      (dmem_addr),
        .DMEM_WDATA     (dmem_wdata),
        .DMEM_BE        (dmem_be),
        .DMEM_ACK       (dmem_ack),
        .DMEM_ERR       (dmem_err),
        .DMEM_RDATA     (dmem_rdata),
        .MEM_STALL      (mem_stall),
        .MEM_RESULT     (mem_result),
        .MEM_LAM        (mem_lam),
        .MEM_LAF        (mem_laf),
        .MEM_SAM        (mem_sam),
        .MEM_SAF        (mem_saf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected outputs for the current cycle, set by the stimulus sequencer.
    bit          chk_on = 0;
    bit          exp_stall, exp_req, exp_lam, exp_sam, exp_laf, exp_saf, exp_we, exp_res_chk;
    logic [63:0] exp_addr, exp_wdata, exp_result;
    logic [7:0]  exp_be;

    // Per-access observations, cleared whenever acc_id changes.
    int          acc_id = 0;
    int          seen_id = 0;
    int          cap_stall_n, cap_req_n, cap_laf_n;
    bit          cap_lam, cap_sam, cap_saf, cap_we;
    logic [7:0]  cap_be;
    logic [63:0] cap_wdata, cap_result;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: byte-by-byte interpretation of the lane rules.
    function automatic logic [7:0] m_be(input int n, input int off);
        logic [7:0] b = '0;
        for (int i = 0; i < 8; i++) b[i] = (i >= off) && (i < off + n);
        return b;
    endfunction

    function automatic logic [63:0] m_wdata(input logic [63:0] d, input int off);
        logic [63:0] w = '0;
        for (int i = 0; i < 8; i++)
            if (i >= off) w[8*i +: 8] = d[8*(i-off) +: 8];
        return w;
    endfunction

    function automatic logic [63:0] m_load(input logic [2:0] f3, input int off, input logic [63:0] rd);
        int          n = 1 << f3[1:0];
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
        if (!f3[2] && n < 8 && v[8*n-1])
            for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_on) begin
                if (acc_id != seen_id) begin
                    seen_id     = acc_id;
                    cap_stall_n = 0; cap_req_n = 0; cap_laf_n = 0;
                    cap_lam = 0; cap_sam = 0; cap_saf = 0; cap_we = 0;
                    cap_be = '0; cap_wdata = '0; cap_result = '0;
                end
                chk("MEM_STALL", mem_stall, exp_stall);
                chk("DMEM_REQ",  dmem_req,  exp_req);
                chk("MEM_LAM",   mem_lam,   exp_lam);
                chk("MEM_SAM",   mem_sam,   exp_sam);
                chk("MEM_LAF",   mem_laf,   exp_laf);
                chk("MEM_SAF",   mem_saf,   exp_saf);
                if (exp_req) begin
                    chk("DMEM_ADDR", dmem_addr, exp_addr);
                    chk("DMEM_WE",   dmem_we,   exp_we);
                    chk("DMEM_BE",   dmem_be,   exp_be);
                    if (exp_we) chk("DMEM_WDATA", dmem_wdata, exp_wdata);
                end
                if (exp_res_chk) chk("MEM_RESULT", mem_result, exp_result);
                if (mem_stall) cap_stall_n++;
                if (mem_laf)   cap_laf_n++;
                if (dmem_req) begin
                    cap_req_n++;
                    cap_be    = dmem_be;
                    cap_we    = dmem_we;
                    cap_wdata = dmem_wdata;
                end
                cap_lam |= mem_lam;
                cap_sam |= mem_sam;
                cap_saf |= mem_saf;
                if (exp_res_chk) cap_result = mem_result;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exp();
        exp_stall = 0; exp_req = 0; exp_lam = 0; exp_sam = 0;
        exp_laf = 0; exp_saf = 0; exp_we = 0; exp_res_chk = 0;
    endtask

    task automatic idle_cycle();
        mem_v = 0; mem_load = 0; mem_store = 0;
        dmem_ack = 0; dmem_err = 0; wb_stall = 0;
        clear_exp();
        tick();
    endtask

    // One MEM-stage access. ack_at = REQ cycle carrying ACK (<=0: never acked).
    task automatic do_access(input bit ld, input bit st, input logic [2:0] f3,
                             input logic [63:0] addr, input logic [63:0] sdata,
                             input int ack_at, input bit err, input logic [63:0] rdata,
                             input int wb_hold);
        bit is_ld, is_st, mis, e;
        int n, off, req_n;
        is_ld = ld;
        is_st = st && !ld;
        n     = 1 << f3[1:0];
        off   = int'(addr[2:0]);
        mis   = (off % n) != 0;
        acc_id++;
        mem_v = 1; mem_load = ld; mem_store = st; mem_funct3 = f3;
        mem_addr = addr; mem_sdata = sdata;
        dmem_ack = 0; dmem_err = 0; wb_stall = 0;
        clear_exp();
        exp_stall = !mis;
        exp_lam   = mis && is_ld;
        exp_sam   = mis && is_st;
        tick();
        if (!mis) begin
            clear_exp();
            exp_req   = 1;
            exp_stall = 1;
            exp_addr  = {addr[63:3], 3'b000};
            exp_we    = is_st;
            exp_be    = m_be(n, off);
            exp_wdata = m_wdata(sdata, off);
            req_n     = (ack_at > 0) ? ack_at : TB_TO;
            for (int k = 1; k <= req_n; k++) begin
                dmem_ack   = (k == ack_at);
                dmem_err   = (k == ack_at) ? err : 1'b1;
                dmem_rdata = (k == ack_at) ? rdata : 64'hA5A5_5A5A_C3C3_3C3C;
                tick();
            end
            e = (ack_at > 0) ? err : 1'b1;
            clear_exp();
            exp_laf     = is_ld && e;
            exp_saf     = is_st && e;
            exp_res_chk = is_ld && (!e || ack_at <= 0);
            exp_result  = (is_ld && !e) ? m_load(f3, off, rdata) : 64'h0;
            for (int h = 0; h <= wb_hold; h++) begin
                wb_stall   = (h < wb_hold);
                dmem_ack   = (h < wb_hold);
                dmem_err   = (h < wb_hold);
                dmem_rdata = ~rdata;
                tick();
            end
        end
        idle_cycle();
    endtask

    initial begin : stim
        rst = 1; mem_v = 0; mem_load = 0; mem_store = 0; mem_funct3 = '0;
        mem_addr = '0; mem_sdata = '0; wb_stall = 0;
        dmem_ack = 0; dmem_err = 0; dmem_rdata = '0;
        clear_exp();
        exp_addr = '0; exp_wdata = '0; exp_result = '0; exp_be = '0;
        exp_res_chk = 1;
        tick();
        chk_on = 1;
        tick();
        rst = 0;
        tick();

        // Not valid: a misaligned load must raise nothing.
        mem_v = 0; mem_load = 1; mem_funct3 = 3'b010; mem_addr = 64'h3;
        clear_exp();
        tick();
        idle_cycle();

        // LB, ACK on third REQ cycle.
        do_access(1, 0, 3'b000, 64'h1003, 64'h0, 3, 0, 64'h0000_0000_80FF_0000, 0);
        chk("LB.be",     cap_be,      64'h08);
        chk("LB.result", cap_result,  64'hFFFF_FFFF_FFFF_FF80);
        chk("LB.stalls", cap_stall_n, 64'd4);
        chk("LB.reqs",   cap_req_n,   64'd3);

        // SH 0xBEEF at 0x2006.
        do_access(0, 1, 3'b001, 64'h2006, 64'hBEEF, 1, 0, 64'h0, 0);
        chk("SH.we",     cap_we,      64'd1);
        chk("SH.be",     cap_be,      64'hC0);
        chk("SH.wdata",  cap_wdata,   64'hBEEF_0000_0000_0000);
        chk("SH.saf",    cap_saf,     64'd0);
        chk("SH.stalls", cap_stall_n, 64'd2);

        // LW misaligned.
        do_access(1, 0, 3'b010, 64'h3002, 64'h0, 1, 0, 64'h0, 0);
        chk("LWmis.lam",    cap_lam,     64'd1);
        chk("LWmis.reqs",   cap_req_n,   64'd0);
        chk("LWmis.stalls", cap_stall_n, 64'd0);

        // LD with bus error, WB stalled for two cycles.
        do_access(1, 0, 3'b011, 64'h4000, 64'h0, 2, 1, 64'h1234_5678_9ABC_DEF0, 2);
        chk("LDerr.laf_cycles", cap_laf_n, 64'd3);

        // Extension variants.
        do_access(1, 0, 3'b101, 64'h10A2, 64'h0, 1, 0, 64'h0000_0000_9ABC_0000, 1);
        chk("LHU.result", cap_result, 64'h0000_0000_0000_9ABC);
        do_access(1, 0, 3'b001, 64'h10A6, 64'h0, 2, 0, 64'h8001_0000_0000_0000, 0);
        chk("LH.result", cap_result, 64'hFFFF_FFFF_FFFF_8001);
        do_access(1, 0, 3'b110, 64'h10A4, 64'h0, 1, 0, 64'hF000_0001_0000_0000, 0);
        chk("LWU.result", cap_result, 64'h0000_0000_F000_0001);
        do_access(1, 0, 3'b010, 64'h10A4, 64'h0, 1, 0, 64'hF000_0001_0000_0000, 0);
        chk("LW.result", cap_result, 64'hFFFF_FFFF_F000_0001);
        do_access(1, 0, 3'b011, 64'h10A8, 64'h0, 1, 0, 64'hFEDC_BA98_7654_3210, 0);
        chk("LD.result", cap_result, 64'hFEDC_BA98_7654_3210);

        // Store variants.
        do_access(0, 1, 3'b000, 64'h2005, 64'hA5, 1, 0, 64'h0, 0);
        chk("SB.be", cap_be, 64'h20);
        do_access(0, 1, 3'b010, 64'h2004, 64'h1122_3344, 2, 0, 64'h0, 0);
        chk("SW.wdata", cap_wdata, 64'h1122_3344_0000_0000);
        do_access(0, 1, 3'b011, 64'h2008, 64'h0102_0304_0506_0708, 2, 0, 64'h0, 0);
        chk("SD.be", cap_be, 64'hFF);
        do_access(0, 1, 3'b011, 64'h200C, 64'h0, 1, 0, 64'h0, 0);
        chk("SDmis.sam", cap_sam, 64'd1);

        // LOAD and STORE both set resolve as a load.
        do_access(1, 1, 3'b011, 64'h7004, 64'h0, 1, 0, 64'h0, 0);
        chk("BOTHmis.sam", cap_sam, 64'd0);
        do_access(1, 1, 3'b010, 64'h700C, 64'hFFFF, 1, 0, 64'h0000_0042_0000_0000, 0);
        chk("BOTH.we", cap_we, 64'd0);

        // Reset while the request is outstanding, then a late ACK.
        acc_id++;
        mem_v = 1; mem_load = 1; mem_store = 0; mem_funct3 = 3'b011; mem_addr = 64'h6000;
        clear_exp();
        exp_stall = 1;
        tick();
        exp_req = 1; exp_addr = 64'h6000; exp_we = 0; exp_be = 8'hFF;
        tick();
        rst = 1;
        tick();
        rst = 0; mem_v = 0; mem_load = 0;
        dmem_ack = 1; dmem_err = 1; dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        clear_exp();
        exp_res_chk = 1; exp_result = 64'h0;
        tick();
        dmem_ack = 0; dmem_err = 0;
        tick();
        exp_res_chk = 0;
        chk("RST.reqs", cap_req_n, 64'd2);
        chk("RST.laf",  cap_laf_n, 64'd0);

`ifdef DMEM_TIMEOUT_EN
        // Unanswered SD: watchdog fires after TB_TO request cycles.
        do_access(0, 1, 3'b011, 64'h5008, 64'h1122_3344_5566_7788, 0, 0, 64'h0, 0);
        chk("TO.reqs", cap_req_n, 64'd4);
        chk("TO.saf",  cap_saf,   64'd1);
        do_access(1, 0, 3'b000, 64'h5001, 64'h0, 0, 0, 64'h0, 0);
        chk("TO.ld_result", cap_result, 64'h0);
`endif

        chk_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Sequences data-memory loads and stores for the MEM pipeline stage. Converts one valid MEM-stage access into a single req/ack transaction on the data-memory port, and stalls the pipeline until the access completes. Aligns and extends load data. Raises the MEM_LAM/LAF/SAM/SAF exception flags consumed by the CSR/trap logic.

Parameters:
XLEN, 64, data and address width
TIMEOUT_CYCLES, 255, cycles spent in WAIT before the watchdog fires (only with DMEM_TIMEOUT_EN)

Ports:
CLK  in  1  core clock
RESET  in  1  synchronous, active-high reset
MEM_V  in  1  MEM-stage instruction valid
MEM_LOAD  in  1  instruction is a load
MEM_STORE  in  1  instruction is a store
MEM_FUNCT3  in  3  size/sign: [1:0] 0=B 1=H 2=W 3=D; [2]=unsigned
MEM_ADDR  in  XLEN  effective address (ALU result)
MEM_STORE_DATA  in  XLEN  rs2 value, right-justified
WB_STALL  in  1  WB cannot accept this cycle
DMEM_REQ  out  1  request valid; held until DMEM_ACK
DMEM_WE  out  1  1=store
DMEM_ADDR  out  XLEN  doubleword-aligned address {MEM_ADDR[63:3],3'b0}
DMEM_WDATA  out  XLEN  store data shifted to its byte lanes
DMEM_BE  out  8  byte enables
DMEM_ACK  in  1  transaction complete (single cycle)
DMEM_ERR  in  1  bus error; valid only with DMEM_ACK
DMEM_RDATA  in  XLEN  read data; valid with DMEM_ACK
MEM_STALL  out  1  hold IF..MEM stages
MEM_RESULT  out  XLEN  aligned, extended load data
MEM_LAM / MEM_LAF / MEM_SAM / MEM_SAF  out  1 each  load/store address-misaligned and access-fault flags

Behaviour:
- FSM states: IDLE, REQ, DONE. Reset forces IDLE. All outputs reset to 0.
- access = MEM_V & (MEM_LOAD | MEM_STORE). If both LOAD and STORE are set, the access is treated as a load.
- Misalignment: H needs addr[0]=0; W needs addr[1:0]=0; D needs addr[2:0]=0.
  - A misaligned access in IDLE asserts LAM (load) or SAM (store) combinationally in the same cycle.
  - No DMEM request is issued and MEM_STALL=0.
- IDLE:
  - Aligned access: register addr, WE, BE, WDATA and funct3; go to REQ next cycle.
  - MEM_STALL=1 combinationally from the first cycle of the access.
- REQ:
  - DMEM_REQ=1; outputs stay stable until DMEM_ACK.
  - On ACK: capture RDATA and ERR, go to DONE.
- DONE:
  - MEM_STALL=0. MEM_RESULT is valid.
  - LAF (load) or SAF (store) equals the captured ERR.
  - If WB_STALL=1, remain in DONE and hold all outputs. Otherwise return to IDLE next cycle.
- MEM_STALL = access & (state != DONE) & !misaligned. Minimum latency is 2 stall cycles for a 0-wait memory (ACK in the first REQ cycle).
- Byte enables: BE = size mask (0x01/0x03/0x0F/0xFF) << addr[2:0]. WDATA = store data << (8*addr[2:0]).
- Load data: (RDATA >> 8*addr[2:0]), truncated to the access size, then sign- or zero-extended per funct3[2]. LD ignores funct3[2].
- After DONE the controller does not re-issue an access for the same instruction. The pipeline advances because MEM_STALL dropped. Back-to-back accesses start from IDLE on the next cycle.
- RESET in REQ: DMEM_REQ drops in the same clock edge. A late ACK arriving in IDLE is ignored.
- ACK without REQ is ignored. ERR without ACK is ignored.

Optional Feature:
DMEM_TIMEOUT_EN:
- Defined: a counter clears on entry to REQ and increments each REQ cycle.
  - At TIMEOUT_CYCLES without ACK, DMEM_REQ drops and the FSM enters DONE with ERR=1, so LAF or SAF is raised and MEM_RESULT=0.
- Undefined: REQ waits indefinitely; no counter is synthesised.

Decomposition:
- Package dmem_pkg holds:
  - the state enum (IDLE/REQ/DONE);
  - funct3 size constants SZ_B/SZ_H/SZ_W/SZ_D;
  - the byte-mask function;
  - the default TIMEOUT_CYCLES.
- One sub-module, dmem_lane_align (purely combinational), handles store-lane shift plus BE generation and load shift plus extension. It is instantiated once.

Test Plan:
- LB addr 0x1003, RDATA 0x0000_0000_80FF_0000 (byte 3 = 0x80), ACK after 3 cycles → BE=0x08, MEM_RESULT=0xFFFF_FFFF_FFFF_FF80, MEM_STALL high for exactly 4 cycles.
- SH data 0xBEEF at addr 0x2006 → DMEM_WE=1, BE=0xC0, WDATA=0xBEEF_0000_0000_0000, SAF=0.
- LW addr 0x3002 → MEM_LAM=1 in the same cycle, DMEM_REQ never asserts, MEM_STALL=0.
- LD addr 0x4000, ACK with ERR=1 → MEM_LAF=1 in DONE. Hold WB_STALL=1 for 2 cycles → DONE and LAF are held, then return to IDLE.
- RESET asserted during REQ → next cycle DMEM_REQ=0, state IDLE, all flags 0. A subsequent ACK produces no output change.
- With DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=4 and no ACK on SD → REQ drops after 4 cycles and MEM_SAF=1.
